uart_rx_path: RTL and testbench

UART receive path, the counterpart of the link's transmit path. It recovers frames from the serial line `rx`: 1 start bit, Data_Width data bits LSB first, an optional parity bit, and 1 stop bit. Each bit lasts OverSampling clk cycles. Received words and their error status go to the fabric through a single-entry valid/ready output register.

---
 rtl/uart_rx_path.sv | 158 +++++++++++++++
 tb/tb_uart_rx_path.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_path.sv
// UART receive path: synchronizes the serial line, recovers start/data/parity/stop
// bits at their centres and hands each word to the fabric through a valid/ready register.
module uart_rx_path #(
   parameter int Data_Width   = 8,
   parameter int OverSampling = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  parity_en,
   input  logic                  parity_type,
   output logic [Data_Width-1:0] data_out,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CW = $clog2(OverSampling);
   localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
   localparam logic [CW-1:0] HalfCount = CW'(OverSampling / 2 - 1);
   localparam logic [CW-1:0] LastCount = CW'(OverSampling - 1);
   localparam logic [BW-1:0] LastBit   = BW'(Data_Width - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   state_t                state;
   logic [CW-1:0]         clk_count;
   logic [BW-1:0]         bit_index;
   logic [Data_Width-1:0] shift_reg;
   logic [Data_Width:0]   shift_ext;
   logic                  par_en_q;
   logic                  par_type_q;
   logic                  parity_err_n;
   logic                  frame_err_n;
   logic                  rx_meta;
   logic                  rx_s;
   logic                  rx_d;

   // Two-flop synchronizer plus one delay stage for falling-edge detection; all
   // three idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign shift_ext = {rx_s, shift_reg};

   // Receive FSM and output register. In DONE the finished word is loaded if the
   // output slot is free or being emptied this cycle; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         clk_count    <= '0;
         bit_index    <= '0;
         shift_reg    <= '0;
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         parity_err_n <= 1'b0;
         frame_err_n  <= 1'b0;
         data_out     <= '0;
         rx_valid     <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (state == IDLE || clk_count == LastCount) begin
            clk_count <= '0;
         end else begin
            clk_count <= clk_count + CW'(1);
         end

         case (state)
            IDLE: begin
               if (rx_d && !rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (clk_count == HalfCount) begin
                  if (!rx_s) begin
                     state        <= DATA;
                     clk_count    <= '0;
                     bit_index    <= '0;
                     par_en_q     <= parity_en;
                     par_type_q   <= parity_type;
                     parity_err_n <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (clk_count == LastCount) begin
                  shift_reg <= shift_ext[Data_Width:1];
                  bit_index <= bit_index + BW'(1);
                  if (bit_index == LastBit) begin
                     state <= par_en_q ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (clk_count == LastCount) begin
                  parity_err_n <= (rx_s != (par_type_q ? ~^shift_reg : ^shift_reg));
                  state        <= STOP;
               end
            end
            STOP: begin
               if (clk_count == LastCount) begin
                  frame_err_n <= ~rx_s;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!rx_valid || rx_ready) begin
                  data_out   <= shift_reg;
                  parity_err <= parity_err_n;
                  frame_err  <= frame_err_n;
                  rx_valid   <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed testbench for uart_rx_path: clean frames, parity, glitch, frame error,
// overrun and mid-frame reset, with hand-computed expectations.
module tb_uart_rx_path;

   localparam int DW = 8;
   localparam int OS = 16;

   logic          clk;
   logic          reset;
   logic          rx;
   logic          parity_en;
   logic          parity_type;
   logic [DW-1:0] data_out;
   logic          rx_valid;
   logic          rx_ready;
   logic          parity_err;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int tests_run;
   int tests_failed;

   int            accept_count;
   int            overrun_count;
   int            valid_cycles;
   logic [DW-1:0] cap_data;
   logic          cap_perr;
   logic          cap_ferr;

   int base_accept;
   int base_valid;
   int base_overrun;

   uart_rx_path #(.Data_Width(DW), .OverSampling(OS)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .parity_en   (parity_en),
      .parity_type (parity_type),
      .data_out    (data_out),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every accepted word and counts overrun pulses and valid cycles.
   initial begin
      accept_count  = 0;
      overrun_count = 0;
      valid_cycles  = 0;
      cap_data      = '0;
      cap_perr      = 1'b0;
      cap_ferr      = 1'b0;
   end

   always @(negedge clk) begin
      if (rx_valid) valid_cycles++;
      if (overrun) overrun_count++;
      if (rx_valid && rx_ready) begin
         accept_count++;
         cap_data = data_out;
         cap_perr = parity_err;
         cap_ferr = frame_err;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic driveBit(input logic b);
      rx = b;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [DW-1:0] data, input logic with_parity,
                                input logic parity_bit, input logic stop_bit,
                                input int idle_cycles);
      driveBit(1'b0);
      for (int i = 0; i < DW; i++) driveBit(data[i]);
      if (with_parity) driveBit(parity_bit);
      driveBit(stop_bit);
      if (idle_cycles > 0) begin
         rx = 1'b1;
         repeat (idle_cycles) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      rx           = 1'b1;
      rx_ready     = 1'b1;
      parity_en    = 1'b0;
      parity_type  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_data_out", 32'(data_out), 32'h00);
      checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Clean frame, parity off
      base_accept = accept_count;
      base_valid  = valid_cycles;
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 8);
      checkOutput("clean_accepts", 32'(accept_count - base_accept), 32'd1);
      checkOutput("clean_valid_cycles", 32'(valid_cycles - base_valid), 32'd1);
      checkOutput("clean_data", 32'(cap_data), 32'hA5);
      checkOutput("clean_parity_err", 32'(cap_perr), 32'd0);
      checkOutput("clean_frame_err", 32'(cap_ferr), 32'd0);

      // Even parity, 0x07 has three ones so the parity bit must be 1
      parity_en   = 1'b1;
      parity_type = 1'b0;
      applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, 8);
      checkOutput("even_ok_data", 32'(cap_data), 32'h07);
      checkOutput("even_ok_parity_err", 32'(cap_perr), 32'd0);
      applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 8);
      checkOutput("even_bad_data", 32'(cap_data), 32'h07);
      checkOutput("even_bad_parity_err", 32'(cap_perr), 32'd1);

      // Odd parity on 0x00 requires a parity bit of 1
      parity_type = 1'b1;
      base_accept = accept_count;
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 8);
      checkOutput("odd_ok_accepts", 32'(accept_count - base_accept), 32'd1);
      checkOutput("odd_ok_data", 32'(cap_data), 32'h00);
      checkOutput("odd_ok_parity_err", 32'(cap_perr), 32'd0);
      parity_en   = 1'b0;
      parity_type = 1'b0;

      // Glitch: four low cycles never survive to the start-bit centre
      base_accept = accept_count;
      base_valid  = valid_cycles;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("glitch_busy_seen", 32'(busy), 32'd1);
      repeat (OS / 2 + 3 - 6 + 1) @(posedge clk);
      #1;
      checkOutput("glitch_busy_cleared", 32'(busy), 32'd0);
      repeat (OS) @(posedge clk);
      #1;
      checkOutput("glitch_no_accept", 32'(accept_count - base_accept), 32'd0);
      checkOutput("glitch_no_valid", 32'(valid_cycles - base_valid), 32'd0);

      // Frame error: stop bit low and the line held low 40 cycles in total
      base_accept = accept_count;
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 0);
      repeat (40 - OS) @(posedge clk);
      #1;
      checkOutput("ferr_accepts", 32'(accept_count - base_accept), 32'd1);
      checkOutput("ferr_data", 32'(cap_data), 32'h3C);
      checkOutput("ferr_flag", 32'(cap_ferr), 32'd1);
      checkOutput("ferr_low_line_idle", 32'(busy), 32'd0);
      rx = 1'b1;
      repeat (OS) @(posedge clk);
      #1;
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 8);
      checkOutput("after_ferr_accepts", 32'(accept_count - base_accept), 32'd2);
      checkOutput("after_ferr_data", 32'(cap_data), 32'h81);
      checkOutput("after_ferr_flag", 32'(cap_ferr), 32'd0);

      // Overrun: consumer stalled while two frames arrive back to back
      rx_ready     = 1'b0;
      base_accept  = accept_count;
      base_overrun = overrun_count;
      applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 0);
      applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, 8);
      checkOutput("ovr_valid_held", 32'(rx_valid), 32'd1);
      checkOutput("ovr_data_kept", 32'(data_out), 32'h11);
      checkOutput("ovr_pulses", 32'(overrun_count - base_overrun), 32'd1);
      rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ovr_consumed", 32'(accept_count - base_accept), 32'd1);
      checkOutput("ovr_consumed_data", 32'(cap_data), 32'h11);
      checkOutput("ovr_valid_dropped", 32'(rx_valid), 32'd0);

      // Reset in the middle of data bit 3
      base_accept = accept_count;
      driveBit(1'b0);
      for (int i = 0; i < 3; i++) driveBit(1'b0);
      rx = 1'b0;
      repeat (OS / 2) @(posedge clk);
      #1;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
      reset = 1'b0;
      repeat (2 * OS) @(posedge clk);
      #1;
      checkOutput("midreset_no_output", 32'(accept_count - base_accept), 32'd0);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 8);
      checkOutput("postreset_accepts", 32'(accept_count - base_accept), 32'd1);
      checkOutput("postreset_data", 32'(cap_data), 32'h5A);
      checkOutput("postreset_frame_err", 32'(cap_ferr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
